// File: rtl/int_ack_dispatch.sv
// Interrupt acknowledge/dispatch: latches a one-hot route address, raises Irq
// with its vector, handshakes Ack/Done and pulses Clr_req back to the source.
module int_ack_dispatch #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Rout_addrs,
    input  logic       Ack,
    input  logic       Done,
    output logic       Irq,
    output logic [1:0] Vec,
    output logic       Busy,
    output logic [3:0] Clr_req,
    output logic       Bad_addr,
    output logic       Tmo_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVE,
        CLEAR
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       addr, addr_nx;
    logic [1:0]       vec_nx, vec_enc;
    logic             bad_nx, tmo_nx;
    logic             one_hot;

    assign one_hot = (Rout_addrs != 4'd0)
                  && ((Rout_addrs & (Rout_addrs - 4'd1)) == 4'd0);

    always_comb begin
        vec_enc = 2'd0;
        case (Rout_addrs)
            4'b0001: vec_enc = 2'd0;
            4'b0010: vec_enc = 2'd1;
            4'b0100: vec_enc = 2'd2;
            4'b1000: vec_enc = 2'd3;
            default: vec_enc = 2'd0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr;
        vec_nx   = Vec;
        bad_nx   = 1'b0;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    addr_nx  = Rout_addrs;
                    vec_nx   = vec_enc;
                    cnt_nx   = '0;
                    state_nx = REQ;
                end else if (Rout_addrs != 4'd0) begin
                    bad_nx = 1'b1;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout expiring the same cycle
                if (Ack) begin
                    state_nx = SERVE;
                end else if (cnt == TMO_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SERVE: begin
                if (Done) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they track state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= 4'd0;
            Irq      <= 1'b0;
            Vec      <= 2'd0;
            Busy     <= 1'b0;
            Clr_req  <= 4'd0;
            Bad_addr <= 1'b0;
            Tmo_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr     <= addr_nx;
            Irq      <= (state_nx == REQ);
            Vec      <= vec_nx;
            Busy     <= (state_nx == SERVE);
            Clr_req  <= (state_nx == CLEAR) ? addr_nx : 4'd0;
            Bad_addr <= bad_nx;
            Tmo_err  <= tmo_nx;
        end
    end

endmodule

// File: tb/tb_int_ack_dispatch.sv
// Scoreboard bench for int_ack_dispatch: expected active-output cycles are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_int_ack_dispatch;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] Rout_addrs;
    logic       Ack;
    logic       Done;
    logic       Irq;
    logic [1:0] Vec;
    logic       Busy;
    logic [3:0] Clr_req;
    logic       Bad_addr;
    logic       Tmo_err;

    int n_checks = 0;
    int n_fails  = 0;
    bit mon_en   = 1'b0;

    // {Irq, Vec[1:0], Busy, Clr_req[3:0], Bad_addr, Tmo_err}
    logic [9:0] exp_q[$];

    int_ack_dispatch #(
        .ACK_TIMEOUT(4),
        .CNT_W      (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Rout_addrs(Rout_addrs),
        .Ack       (Ack),
        .Done      (Done),
        .Irq       (Irq),
        .Vec       (Vec),
        .Busy      (Busy),
        .Clr_req   (Clr_req),
        .Bad_addr  (Bad_addr),
        .Tmo_err   (Tmo_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0] rec(input logic irq, input logic [1:0] vec,
                                       input logic busy, input logic [3:0] clr,
                                       input logic bad, input logic tmo);
        return {irq, vec, busy, clr, bad, tmo};
    endfunction

    task automatic push(input logic [9:0] r);
        exp_q.push_back(r);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every cycle with any active output must match the next entry.
    always @(negedge Clk) begin
        logic [9:0] obs;
        logic [9:0] exp_r;
        obs = {Irq, Vec, Busy, Clr_req, Bad_addr, Tmo_err};
        if (mon_en && (obs[9] || obs[6] || (obs[5:2] != 4'd0) || obs[1] || obs[0])) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_output: got %b, required no active output", obs);
            end else begin
                exp_r = exp_q.pop_front();
                if (obs !== exp_r) begin
                    n_fails++;
                    $display("FAIL output_cycle: got %b, required %b", obs, exp_r);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        logic [9:0] obs;
        obs = {Irq, Vec, Busy, Clr_req, Bad_addr, Tmo_err};
        n_checks++;
        if (obs !== 10'd0) begin
            n_fails++;
            $display("FAIL %s: got %b, required %b", name, obs, 10'd0);
        end
    endtask

    initial begin
        Rst = 1'b1; Rout_addrs = 4'd0; Ack = 1'b0; Done = 1'b0;
        cyc(); cyc();
        Rst = 1'b0;
        check_idle("reset_state");
        mon_en = 1'b1;
        cyc();

        // basic handshake, 0100
        push(rec(1, 2'd2, 0, 4'd0, 0, 0));
        push(rec(0, 2'd2, 1, 4'd0, 0, 0));
        push(rec(0, 2'd2, 0, 4'b0100, 0, 0));
        Rout_addrs = 4'b0100; cyc();
        Rout_addrs = 4'd0; Ack = 1'b1; cyc();
        Ack = 1'b0; Done = 1'b1; cyc();
        Done = 1'b0; cyc(); cyc();

        // timeout with no Ack, then re-request with Ack in last Irq cycle
        for (int i = 0; i < 4; i++) push(rec(1, 2'd0, 0, 4'd0, 0, 0));
        push(rec(0, 2'd0, 0, 4'd0, 0, 1));
        for (int i = 0; i < 4; i++) push(rec(1, 2'd0, 0, 4'd0, 0, 0));
        push(rec(0, 2'd0, 1, 4'd0, 0, 0));
        push(rec(0, 2'd0, 0, 4'b0001, 0, 0));
        Rout_addrs = 4'b0001; cyc();
        Rout_addrs = 4'd0;
        for (int i = 0; i < 4; i++) cyc();
        Rout_addrs = 4'b0001; cyc();
        Rout_addrs = 4'd0; cyc(); cyc(); cyc();
        Ack = 1'b1; cyc();
        Ack = 1'b0; Done = 1'b1; cyc();
        Done = 1'b0; cyc(); cyc();

        // bad address then valid 1000
        push(rec(0, 2'd0, 0, 4'd0, 1, 0));
        push(rec(1, 2'd3, 0, 4'd0, 0, 0));
        push(rec(0, 2'd3, 1, 4'd0, 0, 0));
        push(rec(0, 2'd3, 0, 4'b1000, 0, 0));
        Rout_addrs = 4'b0110; cyc();
        Rout_addrs = 4'b1000; cyc();
        Rout_addrs = 4'd0; Ack = 1'b1; cyc();
        Ack = 1'b0; Done = 1'b1; cyc();
        Done = 1'b0; cyc(); cyc();

        // input change while busy
        push(rec(1, 2'd1, 0, 4'd0, 0, 0));
        push(rec(1, 2'd1, 0, 4'd0, 0, 0));
        push(rec(0, 2'd1, 1, 4'd0, 0, 0));
        push(rec(0, 2'd1, 1, 4'd0, 0, 0));
        push(rec(0, 2'd1, 0, 4'b0010, 0, 0));
        push(rec(1, 2'd0, 0, 4'd0, 0, 0));
        push(rec(0, 2'd0, 1, 4'd0, 0, 0));
        push(rec(0, 2'd0, 0, 4'b0001, 0, 0));
        Rout_addrs = 4'b0010; cyc();
        Rout_addrs = 4'b0001; cyc();
        Ack = 1'b1; cyc();
        Ack = 1'b0; cyc();
        Done = 1'b1; cyc();
        Done = 1'b0; cyc();
        cyc();
        Rout_addrs = 4'd0; Ack = 1'b1; cyc();
        Ack = 1'b0; Done = 1'b1; cyc();
        Done = 1'b0; cyc(); cyc();

        // reset during SERVE aborts with no Clr_req
        push(rec(1, 2'd3, 0, 4'd0, 0, 0));
        push(rec(0, 2'd3, 1, 4'd0, 0, 0));
        Rout_addrs = 4'b1000; cyc();
        Rout_addrs = 4'd0; Ack = 1'b1; cyc();
        Ack = 1'b0; Rst = 1'b1; Done = 1'b1; cyc();
        check_idle("reset_mid_serve");
        cyc();
        Rst = 1'b0; Done = 1'b0;
        check_idle("after_reset");
        cyc(); cyc(); cyc();

        while (exp_q.size() != 0) begin
            logic [9:0] r;
            r = exp_q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL missing_output: got none, required %b", r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
